// File: rtl/rx_gen_pkg.sv
// Shared types and constants for the receive-path frame generator.
// The LFSR helpers are only referenced when RXGEN_LFSR_EN is defined.
package rx_gen_pkg;

   typedef enum logic [2:0] {IDLE, PR, RXD, SAMP, GAP, END} state_t;

   localparam logic [1:0] MODE_RAMP = 2'd0;
   localparam logic [1:0] MODE_TAG  = 2'd1;
   localparam logic [1:0] MODE_LFSR = 2'd2;

   // x^16+x^14+x^13+x^11+1 -> feedback from bits 15, 13, 12, 10
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'b1011_0100_0000_0000;

   // Bits needed to hold a down-count starting at n-1.
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic logic [15:0] lfsr_seed(input int lane);
      return LFSR_SEED ^ 16'(lane + 1);
   endfunction

   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return {v[14:0], ^(v & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/rx_pattern_lane.sv
// One receive channel's echo data generator: ramp, tag or LFSR pattern.
// LFSR lane is only built when RXGEN_LFSR_EN is defined; otherwise mode 2 gives the ramp.
module rx_pattern_lane
   import rx_gen_pkg::*;
#(
   parameter int LANE    = 0,
   parameter int DATA_W  = 12,
   parameter int SW      = 1,
   parameter int CH_STEP = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              samp_en,
   input  logic              reseed,
   input  logic [1:0]        mode,
   input  logic [SW-1:0]     samp_idx,
   input  logic [DATA_W-1:0] tag_base,
   output logic [DATA_W-1:0] data
);

   localparam logic [DATA_W-1:0] RAMP_OFS = DATA_W'(LANE * CH_STEP);

   logic [DATA_W-1:0] data_d, data_q;

`ifdef RXGEN_LFSR_EN
   logic [15:0] lfsr_d, lfsr_q;

   // The lane presents the current LFSR value, then advances it behind the sample.
   always_comb begin
      lfsr_d = lfsr_q;
      if (reseed)
         lfsr_d = lfsr_seed(LANE);
      else if (samp_en)
         lfsr_d = lfsr_next(lfsr_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lfsr_q <= lfsr_seed(LANE);
      else        lfsr_q <= lfsr_d;
   end
`else
   logic reseed_unused;
   assign reseed_unused = reseed;
`endif

   always_comb begin
      data_d = '0;
      if (samp_en) begin
         case (mode)
            MODE_TAG:  data_d = tag_base + DATA_W'(LANE);
`ifdef RXGEN_LFSR_EN
            MODE_LFSR: data_d = lfsr_q[DATA_W-1:0];
`endif
            default:   data_d = DATA_W'(samp_idx) + RAMP_OFS;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) data_q <= '0;
      else        data_q <= data_d;
   end

   assign data = data_q;

endmodule

// File: rtl/rx_frame_gen.sv
// Frame sequencer for the receive-path stimulus generator: firing timing, gates and tags.
// Define RXGEN_LFSR_EN to build the mode-2 LFSR lanes.
module rx_frame_gen
   import rx_gen_pkg::*;
#(
   parameter int CH_NUM     = 8,
   parameter int DATA_W     = 12,
   parameter int LINE_W     = 8,
   parameter int FOCUS_W    = 2,
   parameter int LINE_NUM   = 128,
   parameter int FOCUS_NUM  = 4,
   parameter int PR_CYC     = 16,
   parameter int RX_DLY     = 8,
   parameter int SAMPLE_NUM = 1024,
   parameter int GAP_CYC    = 4,
   parameter int END_CYC    = 8,
   parameter int CH_STEP    = 256
) (
   input  logic                     clk_50M,
   input  logic                     reset_n,
   input  logic                     run,
   input  logic [1:0]               mode,
   output logic [CH_NUM*DATA_W-1:0] data,
   output logic                     data_valid,
   output logic [LINE_W-1:0]        line_num,
   output logic [FOCUS_W-1:0]       focus_num,
   output logic                     pr_gate,
   output logic                     rx_gate,
   output logic                     sample_gate,
   output logic                     end_gate,
   output logic                     busy
);

   localparam int M1      = (PR_CYC > RX_DLY) ? PR_CYC : RX_DLY;
   localparam int M2      = (M1 > SAMPLE_NUM) ? M1 : SAMPLE_NUM;
   localparam int M3      = (M2 > GAP_CYC) ? M2 : GAP_CYC;
   localparam int MAX_CYC = (M3 > END_CYC) ? M3 : END_CYC;
   localparam int CW      = cnt_w(MAX_CYC);

   localparam logic [CW-1:0]      PR_LD      = CW'(PR_CYC - 1);
   localparam logic [CW-1:0]      RX_LD      = CW'((RX_DLY > 0) ? RX_DLY - 1 : 0);
   localparam logic [CW-1:0]      SAMP_LD    = CW'(SAMPLE_NUM - 1);
   localparam logic [CW-1:0]      GAP_LD     = CW'(GAP_CYC - 1);
   localparam logic [CW-1:0]      END_LD     = CW'(END_CYC - 1);
   localparam logic [LINE_W-1:0]  LAST_LINE  = LINE_W'(LINE_NUM - 1);
   localparam logic [FOCUS_W-1:0] LAST_FOCUS = FOCUS_W'(FOCUS_NUM - 1);

   state_t              state_d, state_q;
   logic [CW-1:0]       cnt_d, cnt_q, cnt_dec;
   logic [LINE_W-1:0]   line_d, line_q;
   logic [FOCUS_W-1:0]  focus_d, focus_q;
   logic [1:0]          mode_d, mode_q, mode_lat;
   logic                reseed;
   logic                pr_d, pr_q, rx_d, rx_q, samp_d, samp_q, end_d, end_q, busy_d, busy_q;
   logic [CW-1:0]       samp_idx_d;
   logic [DATA_W-1:0]   tag_base;

   assign cnt_dec  = cnt_q - CW'(1);
   assign mode_lat = (mode == 2'd3) ? MODE_RAMP : mode;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_dec;
      line_d  = line_q;
      focus_d = focus_q;
      mode_d  = mode_q;
      reseed  = 1'b0;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (run) begin
               state_d = PR;
               cnt_d   = PR_LD;
               line_d  = '0;
               focus_d = '0;
               mode_d  = mode_lat;
               reseed  = 1'b1;
            end
         end
         PR: if (cnt_q == '0) begin
            if (RX_DLY > 0) begin
               state_d = RXD;
               cnt_d   = RX_LD;
            end else begin
               state_d = SAMP;
               cnt_d   = SAMP_LD;
            end
         end
         RXD: if (cnt_q == '0) begin
            state_d = SAMP;
            cnt_d   = SAMP_LD;
         end
         SAMP: if (cnt_q == '0) begin
            state_d = GAP;
            cnt_d   = GAP_LD;
         end
         GAP: if (cnt_q == '0) begin
            if (line_q == LAST_LINE && focus_q == LAST_FOCUS) begin
               state_d = END;
               cnt_d   = END_LD;
            end else begin
               state_d = PR;
               cnt_d   = PR_LD;
               if (focus_q == LAST_FOCUS) begin
                  focus_d = '0;
                  line_d  = line_q + LINE_W'(1);
               end else begin
                  focus_d = focus_q + FOCUS_W'(1);
               end
            end
         end
         END: if (cnt_q == '0) begin
            // run is only honoured here: a new frame starts clean, otherwise go quiet.
            line_d  = '0;
            focus_d = '0;
            if (run) begin
               state_d = PR;
               cnt_d   = PR_LD;
               mode_d  = mode_lat;
               reseed  = 1'b1;
            end else begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign pr_d       = (state_d == PR);
   assign rx_d       = (state_d == RXD) || (state_d == SAMP);
   assign samp_d     = (state_d == SAMP);
   assign end_d      = (state_d == END);
   assign busy_d     = (state_d != IDLE);
   assign samp_idx_d = SAMP_LD - cnt_d;
   assign tag_base   = DATA_W'((int'(line_q) * FOCUS_NUM + int'(focus_q)) * CH_NUM);

   always_ff @(posedge clk_50M or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         line_q  <= '0;
         focus_q <= '0;
         mode_q  <= MODE_RAMP;
         pr_q    <= 1'b0;
         rx_q    <= 1'b0;
         samp_q  <= 1'b0;
         end_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         line_q  <= line_d;
         focus_q <= focus_d;
         mode_q  <= mode_d;
         pr_q    <= pr_d;
         rx_q    <= rx_d;
         samp_q  <= samp_d;
         end_q   <= end_d;
         busy_q  <= busy_d;
      end
   end

   for (genvar k = 0; k < CH_NUM; k++) begin : g_lane
      rx_pattern_lane #(
         .LANE    (k),
         .DATA_W  (DATA_W),
         .SW      (CW),
         .CH_STEP (CH_STEP)
      ) u_lane (
         .clk      (clk_50M),
         .rst_n    (reset_n),
         .samp_en  (samp_d),
         .reseed   (reseed),
         .mode     (mode_q),
         .samp_idx (samp_idx_d),
         .tag_base (tag_base),
         .data     (data[k*DATA_W +: DATA_W])
      );
   end

   assign line_num    = line_q;
   assign focus_num   = focus_q;
   assign pr_gate     = pr_q;
   assign rx_gate     = rx_q;
   assign sample_gate = samp_q;
   assign data_valid  = samp_q;
   assign end_gate    = end_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_rx_frame_gen.sv
// Scoreboard bench for rx_frame_gen: per-cycle expected output vectors queued from a frame model.
// Mode-2 expectations follow RXGEN_LFSR_EN (LFSR lanes) or fall back to the ramp.
module tb_rx_frame_gen;

   localparam int CH         = 2;
   localparam int DATA_W     = 12;
   localparam int LINE_W     = 8;
   localparam int FOCUS_W    = 2;
   localparam int LINE_NUM   = 2;
   localparam int FOCUS_NUM  = 2;
   localparam int PR_CYC     = 3;
   localparam int RX_DLY     = 2;
   localparam int SAMPLE_NUM = 4;
   localparam int GAP_CYC    = 1;
   localparam int END_CYC    = 2;
   localparam int CH_STEP    = 256;
   localparam int DW         = CH * DATA_W;
   localparam int VW         = 6 + FOCUS_W + LINE_W + DW;

   logic                clk_50M;
   logic                reset_n;
   logic                run;
   logic [1:0]          mode;
   logic [DW-1:0]       data;
   logic                data_valid;
   logic [LINE_W-1:0]   line_num;
   logic [FOCUS_W-1:0]  focus_num;
   logic                pr_gate, rx_gate, sample_gate, end_gate, busy;
   logic [VW-1:0]       act_v;

   logic [VW-1:0] exp_q[$];
   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   rx_frame_gen #(
      .CH_NUM(CH), .DATA_W(DATA_W), .LINE_W(LINE_W), .FOCUS_W(FOCUS_W),
      .LINE_NUM(LINE_NUM), .FOCUS_NUM(FOCUS_NUM), .PR_CYC(PR_CYC), .RX_DLY(RX_DLY),
      .SAMPLE_NUM(SAMPLE_NUM), .GAP_CYC(GAP_CYC), .END_CYC(END_CYC), .CH_STEP(CH_STEP)
   ) dut (
      .clk_50M(clk_50M), .reset_n(reset_n), .run(run), .mode(mode),
      .data(data), .data_valid(data_valid), .line_num(line_num), .focus_num(focus_num),
      .pr_gate(pr_gate), .rx_gate(rx_gate), .sample_gate(sample_gate),
      .end_gate(end_gate), .busy(busy)
   );

   assign act_v = {busy, end_gate, sample_gate, rx_gate, pr_gate, data_valid,
                   focus_num, line_num, data};

   // clock / reset
   initial clk_50M = 1'b0;
   always #5 clk_50M = ~clk_50M;

   task automatic check(input string tag, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [VW-1:0] mk(input logic b, input logic e, input logic s,
                                        input logic r, input logic p, input int l,
                                        input int f, input logic [DW-1:0] d);
      return {b, e, s, r, p, s, FOCUS_W'(f), LINE_W'(l), d};
   endfunction

   // Queue one full frame of expected per-cycle output vectors.
   task automatic push_frame(input int md);
      logic [DW-1:0] d;
      int val;
`ifdef RXGEN_LFSR_EN
      logic [15:0] lf[CH];
      for (int k = 0; k < CH; k++) lf[k] = 16'hACE1 ^ 16'(k + 1);
`endif
      for (int l = 0; l < LINE_NUM; l++) begin
         for (int f = 0; f < FOCUS_NUM; f++) begin
            repeat (PR_CYC) exp_q.push_back(mk(1, 0, 0, 0, 1, l, f, '0));
            repeat (RX_DLY) exp_q.push_back(mk(1, 0, 0, 1, 0, l, f, '0));
            for (int s = 0; s < SAMPLE_NUM; s++) begin
               d = '0;
               for (int k = 0; k < CH; k++) begin
                  if (md == 1) val = (l * FOCUS_NUM + f) * CH + k;
                  else         val = s + k * CH_STEP;
`ifdef RXGEN_LFSR_EN
                  if (md == 2) begin
                     val = int'(lf[k][DATA_W-1:0]);
                     lf[k] = {lf[k][14:0], lf[k][15] ^ lf[k][13] ^ lf[k][12] ^ lf[k][10]};
                  end
`endif
                  d[k*DATA_W +: DATA_W] = DATA_W'(val);
               end
               exp_q.push_back(mk(1, 0, 1, 1, 0, l, f, d));
            end
            repeat (GAP_CYC) exp_q.push_back(mk(1, 0, 0, 0, 0, l, f, '0));
         end
      end
      repeat (END_CYC) exp_q.push_back(mk(1, 1, 0, 0, 0, LINE_NUM - 1, FOCUS_NUM - 1, '0));
   endtask

   // Advance n cycles, comparing outputs at each falling edge; empty queue means idle.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk_50M);
         cyc++;
         if (exp_q.size() > 0) check($sformatf("cyc%0d", cyc), act_v, exp_q.pop_front());
         else                  check($sformatf("idle%0d", cyc), act_v, '0);
      end
   endtask

   initial begin
      reset_n = 1'b0;
      run     = 1'b0;
      mode    = 2'd0;
      @(negedge clk_50M);
      check("reset", act_v, '0);
      step(2);
      reset_n = 1'b1;
      step(3);

      // Back-to-back frames; mode changes mid-frame only take effect at the next frame.
      run  = 1'b1;
      mode = 2'd0;
      push_frame(0);
      push_frame(0);
      push_frame(1);
      push_frame(2);
      step(42);
      step(5);
      mode = 2'd1;
      step(37);
      step(5);
      mode = 2'd2;
      step(37);
      // Drop run during firing (0,1); the frame still completes, then idle.
      step(12);
      run = 1'b0;
      step(30);
      step(6);

      // Asynchronous reset in the middle of the first sample window.
      mode = 2'd0;
      run  = 1'b1;
      push_frame(0);
      step(6);
      #2 reset_n = 1'b0;
      #1 check("async_rst", act_v, '0);
      exp_q.delete();
      step(1);
      reset_n = 1'b1;
      push_frame(0);
      step(10);
      run = 1'b0;
      step(32);
      step(5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rx_frame_gen.md
Name: rx_frame_gen

Overview:
Parametrised receive-path stimulus generator for the ultrasound beamformer simulation and bring-up fabric. It sequences firings for a frame (line outer loop, focus inner loop) and drives the PR/RX/sample/end gates with the line and focus tags. During each sample window it emits CH_NUM channels of DATA_W-bit echo data from a selectable pattern. It is the generalised successor to the fixed 8-channel/12-bit generator, adding start/stop control, programmable timing and pattern modes.

Parameters:
CH_NUM, 8, number of receive channels (≥1)
DATA_W, 12, bits per channel sample (1..16)
LINE_W, 8, width of line_num
FOCUS_W, 2, width of focus_num
LINE_NUM, 128, lines per frame (1..2^LINE_W)
FOCUS_NUM, 4, focal zones per line (1..2^FOCUS_W)
PR_CYC, 16, pr_gate high cycles per firing (≥1)
RX_DLY, 8, rx_gate-only cycles before sampling (≥0)
SAMPLE_NUM, 1024, sample_gate cycles per firing (≥1)
GAP_CYC, 4, idle cycles after each firing (≥1)
END_CYC, 8, end_gate high cycles per frame (≥1)
CH_STEP, 256, per-channel ramp offset

Ports:
clk_50M  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
run  in  1  level: generate frames while high
mode  in  2  pattern: 0 ramp, 1 tag, 2 LFSR, 3 reserved (treated as 0)
data  out  CH_NUM*DATA_W  channel k at bits [k*DATA_W +: DATA_W]
data_valid  out  1  high exactly when sample_gate high
line_num  out  LINE_W  current line
focus_num  out  FOCUS_W  current focus
pr_gate  out  1  pulse-repetition/transmit gate
rx_gate  out  1  receive window
sample_gate  out  1  ADC sample window
end_gate  out  1  frame-end marker
busy  out  1  high in every state except IDLE

Behaviour:
- All outputs registered. Reset: state IDLE, all gates/data_valid/busy 0, data 0, line_num 0, focus_num 0, counters 0, LFSRs reseeded.
- FSM: IDLE, PR, RXD, SAMP, GAP, END. One down-counter is shared across all states.
- IDLE: when run=1, move to PR on the next edge. line=0, focus=0, mode latched for the whole frame.
- PR: pr_gate=1 for PR_CYC cycles -> RXD, or directly to SAMP if RX_DLY=0.
- RXD: rx_gate=1 for RX_DLY cycles -> SAMP.
- SAMP: rx_gate=sample_gate=data_valid=1 for SAMPLE_NUM cycles. Sample index s runs 0..SAMPLE_NUM-1. -> GAP.
- GAP: all gates 0 for GAP_CYC cycles. If line=LINE_NUM-1 and focus=FOCUS_NUM-1 -> END. Otherwise advance focus, wrapping to 0 and incrementing line, then -> PR.
- END: end_gate=1 for END_CYC cycles. Tags hold the last firing's values. Exit: if run=1 -> PR with line=focus=0, mode re-latched, LFSRs reseeded. Else -> IDLE with tags reset to 0.
- Firing length = PR_CYC+RX_DLY+SAMPLE_NUM+GAP_CYC. Frame length = LINE_NUM*FOCUS_NUM*firing + END_CYC.
- run deassert mid-frame: the current frame completes; it is sampled only at END exit. run is ignored outside IDLE/END exit.
- Tags update on the first PR cycle of a firing and stay stable through GAP.
- Data is 0 whenever data_valid=0.
- Ramp: ch k = (s + k*CH_STEP) mod 2^DATA_W.
- Tag: ch k = ((line*FOCUS_NUM+focus)*CH_NUM + k) mod 2^DATA_W, constant across the firing.
- LFSR: per-channel 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, seed 16'hACE1 ^ (k+1). Steps once per SAMP cycle after output. ch k = lfsr[DATA_W-1:0]. Reseeded at frame start only.
- Reset mid-operation: immediate async return to reset state. No partial-frame resume.

Optional Feature:
RXGEN_LFSR_EN: defined -> mode 2 LFSR lanes are built as above. Undefined -> no LFSR logic is instantiated and mode 2 behaves as mode 0 (ramp).

Decomposition:
- Package rx_gen_pkg: state enum (IDLE, PR, RXD, SAMP, GAP, END), mode constants (MODE_RAMP=0, MODE_TAG=1, MODE_LFSR=2), LFSR seed and tap constants, count-width helper based on $clog2.
- Sub-module rx_pattern_lane: one channel's ramp/tag/LFSR generator, parametrised by lane index. Generate-instantiated CH_NUM times. The top block holds the FSM, counters and tags.

Test Plan:
Common parameters: CH_NUM=2, LINE_NUM=2, FOCUS_NUM=2, PR_CYC=3, RX_DLY=2, SAMPLE_NUM=4, GAP_CYC=1, END_CYC=2.
- run=1 held, mode=0 -> pr_gate 3 cycles, rx_gate 6 cycles, sample_gate 4 cycles; firing = 10 cycles; end_gate after cycle 40; frame = 42 cycles; second frame restarts at line 0 / focus 0.
- mode=0, CH_STEP=256 -> ch0 = 0,1,2,3 and ch1 = 256,257,258,259 per firing; data=0 in GAP.
- mode=1 -> firing (line1, focus0) shows ch0=4, ch1=5 for all 4 samples; tag order is (0,0),(0,1),(1,0),(1,1).
- run dropped during firing (0,1) -> frame completes through END, then IDLE, busy=0, tags 0; no further gates.
- reset_n pulsed low mid-SAMP -> all outputs 0 asynchronously; after release with run=1, frame restarts from line 0 with PR.
- mode=2 with RXGEN_LFSR_EN -> ch0 first sample = 16'hACE0[11:0]=12'hCE0, ch1 = 16'hACE3[11:0]=12'hCE3; without the macro, outputs equal the ramp values.
